// File: rtl/tb_mem_arb_pkg.sv
// Purpose: shared types for the testbench RAM arbiter (requester id, request beat, response tag).
// Latency: n/a (types and a pure decode helper only).
// Backpressure: n/a.
package tb_mem_arb_pkg;

   typedef enum logic {
      REQ_CORE = 1'b0,
      REQ_DBG  = 1'b1
   } requester_e;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } obi_req_t;

   // Tag travelling alongside the RAM access. 'we' is carried so that a write
   // response can return zero data without looking at the RAM read bus.
   typedef struct packed {
      logic       valid;
      requester_e owner;
      logic       err;
      logic       we;
   } rsp_meta_t;

   // True when addr falls in the RAM window; bits below 'aw' are the offset.
   function automatic logic in_window(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int unsigned aw);
      return (addr >> aw) == (base >> aw);
   endfunction

endpackage

// File: rtl/tb_mem_arbiter_if.sv
// Purpose: one OBI-style requester port (request side + response side).
// Latency: n/a (wiring only).
// Backpressure: request held until gnt; responses are never stalled.
// Signals: req/addr/we/be/wdata driven by the requester, gnt/rvalid/rdata/err by the arbiter.
interface tb_mem_arbiter_if;

   logic        req;
   logic        gnt;
   logic [31:0] addr;
   logic        we;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;

   modport master (
      output req, addr, we, be, wdata,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, addr, we, be, wdata,
      output gnt, rvalid, rdata, err
   );

endinterface

// File: rtl/tb_rsp_pipe.sv
// Purpose: delay line for response tags, aligning them with the RAM read data.
// Latency: DEPTH cycles from in_meta to out_meta.
// Backpressure: none; shifts every cycle, cleared synchronously by rst_i.
// Ports: clk_i, rst_i, in_meta (tag loaded at grant), out_meta (tag due this cycle).
module tb_rsp_pipe
   import tb_mem_arb_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  rsp_meta_t in_meta,
   output rsp_meta_t out_meta
);

   rsp_meta_t stage [DEPTH];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= in_meta;
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign out_meta = stage[DEPTH-1];

endmodule

// File: rtl/tb_mem_arbiter.sv
// Purpose: round-robin share of one RAM port between core and debug requesters, with window decode.
// Latency: gnt combinational; rvalid exactly RAM_LATENCY cycles after gnt.
// Backpressure: losing requester waits (gnt=0); responses cannot be stalled.
// Ports: clk_i, rst_i (sync, active-high), core/dbg requester interfaces, ram_* RAM data port.
module tb_mem_arbiter
   import tb_mem_arb_pkg::*;
#(
   parameter int          RAM_ADDR_WIDTH = 22,
   parameter logic [31:0] BASE_ADDR      = 32'h0,
   parameter int          RAM_LATENCY    = 1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   tb_mem_arbiter_if.slave           core,
   tb_mem_arbiter_if.slave           dbg,
   output logic                      ram_req_o,
   output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
   output logic                      ram_we_o,
   output logic [3:0]                ram_be_o,
   output logic [31:0]               ram_wdata_o,
   input  logic [31:0]               ram_rdata_i
);

   requester_e rr_ptr;
   logic       core_req, dbg_req;
   logic       gnt_core, gnt_dbg, gnt_any;
   obi_req_t   win;
   logic       hit;
   rsp_meta_t  pipe_in, pipe_out;
   logic       rsp_ok, rsp_data_ok;

   // Requests are masked during reset so nothing is granted or issued.
   assign core_req = core.req & ~rst_i;
   assign dbg_req  = dbg.req  & ~rst_i;

   // A lone requester always wins; on contention the pointer owner wins.
   assign gnt_core = core_req & (~dbg_req  | (rr_ptr == REQ_CORE));
   assign gnt_dbg  = dbg_req  & (~core_req | (rr_ptr == REQ_DBG));
   assign gnt_any  = gnt_core | gnt_dbg;

   assign core.gnt = gnt_core;
   assign dbg.gnt  = gnt_dbg;

   always_comb begin
      win = '0;
      if (gnt_dbg) begin
         win.addr  = dbg.addr;
         win.we    = dbg.we;
         win.be    = dbg.be;
         win.wdata = dbg.wdata;
      end else if (gnt_core) begin
         win.addr  = core.addr;
         win.we    = core.we;
         win.be    = core.be;
         win.wdata = core.wdata;
      end
   end

   assign hit = in_window(win.addr, BASE_ADDR, RAM_ADDR_WIDTH);

   // Out-of-window beats are still granted but never reach the RAM.
   assign ram_req_o   = gnt_any & hit;
   assign ram_addr_o  = ram_req_o ? win.addr[RAM_ADDR_WIDTH-1:0] : '0;
   assign ram_we_o    = ram_req_o & win.we;
   assign ram_be_o    = ram_req_o ? win.be    : 4'h0;
   assign ram_wdata_o = ram_req_o ? win.wdata : 32'h0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr <= REQ_CORE;
      end else if (gnt_core) begin
         rr_ptr <= REQ_DBG;
      end else if (gnt_dbg) begin
         rr_ptr <= REQ_CORE;
      end
   end

   always_comb begin
      pipe_in       = '0;
      pipe_in.valid = gnt_any;
      pipe_in.owner = gnt_dbg ? REQ_DBG : REQ_CORE;
      pipe_in.err   = gnt_any & ~hit;
      pipe_in.we    = win.we;
   end

   tb_rsp_pipe #(
      .DEPTH (RAM_LATENCY)
   ) u_rsp_pipe (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .in_meta  (pipe_in),
      .out_meta (pipe_out)
   );

   // A tag emerging while reset is held belongs to a dropped access.
   assign rsp_ok      = pipe_out.valid & ~rst_i;
   assign rsp_data_ok = rsp_ok & ~pipe_out.err & ~pipe_out.we;

   assign core.rvalid = rsp_ok & (pipe_out.owner == REQ_CORE);
   assign core.err    = core.rvalid & pipe_out.err;
   assign core.rdata  = (rsp_data_ok & (pipe_out.owner == REQ_CORE)) ? ram_rdata_i : 32'h0;

   assign dbg.rvalid  = rsp_ok & (pipe_out.owner == REQ_DBG);
   assign dbg.err     = dbg.rvalid & pipe_out.err;
   assign dbg.rdata   = (rsp_data_ok & (pipe_out.owner == REQ_DBG)) ? ram_rdata_i : 32'h0;

endmodule

// File: tb/tb_tb_mem_arbiter.sv
// Purpose: directed bench for tb_mem_arbiter at RAM_LATENCY 1 (index 0) and 3 (index 1).
// Latency: inputs change 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: n/a; the bench always accepts responses.
module tb_tb_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        c_req, c_we, d_req, d_we;
   logic [31:0] c_addr, c_wdata, d_addr, d_wdata, rdata;
   logic [3:0]  c_be, d_be;

   tb_mem_arbiter_if core1 ();
   tb_mem_arbiter_if dbg1 ();
   tb_mem_arbiter_if core3 ();
   tb_mem_arbiter_if dbg3 ();

   assign core1.req = c_req;  assign core1.addr = c_addr; assign core1.we = c_we;
   assign core1.be  = c_be;   assign core1.wdata = c_wdata;
   assign core3.req = c_req;  assign core3.addr = c_addr; assign core3.we = c_we;
   assign core3.be  = c_be;   assign core3.wdata = c_wdata;
   assign dbg1.req  = d_req;  assign dbg1.addr = d_addr;  assign dbg1.we = d_we;
   assign dbg1.be   = d_be;   assign dbg1.wdata = d_wdata;
   assign dbg3.req  = d_req;  assign dbg3.addr = d_addr;  assign dbg3.we = d_we;
   assign dbg3.be   = d_be;   assign dbg3.wdata = d_wdata;

   logic        rr [2];
   logic [21:0] ra [2];
   logic        rw [2];
   logic [3:0]  rb [2];
   logic [31:0] rwd [2];

   tb_mem_arbiter #(.RAM_ADDR_WIDTH(22), .BASE_ADDR(32'h0), .RAM_LATENCY(1)) dut1 (
      .clk_i(clk), .rst_i(rst), .core(core1), .dbg(dbg1),
      .ram_req_o(rr[0]), .ram_addr_o(ra[0]), .ram_we_o(rw[0]), .ram_be_o(rb[0]),
      .ram_wdata_o(rwd[0]), .ram_rdata_i(rdata));

   tb_mem_arbiter #(.RAM_ADDR_WIDTH(22), .BASE_ADDR(32'h0), .RAM_LATENCY(3)) dut3 (
      .clk_i(clk), .rst_i(rst), .core(core3), .dbg(dbg3),
      .ram_req_o(rr[1]), .ram_addr_o(ra[1]), .ram_we_o(rw[1]), .ram_be_o(rb[1]),
      .ram_wdata_o(rwd[1]), .ram_rdata_i(rdata));

   logic        gc [2], gd [2], cv [2], dv [2], ce [2], de [2];
   logic [31:0] cr [2], dr [2];
   assign gc[0] = core1.gnt;    assign gc[1] = core3.gnt;
   assign gd[0] = dbg1.gnt;     assign gd[1] = dbg3.gnt;
   assign cv[0] = core1.rvalid; assign cv[1] = core3.rvalid;
   assign dv[0] = dbg1.rvalid;  assign dv[1] = dbg3.rvalid;
   assign ce[0] = core1.err;    assign ce[1] = core3.err;
   assign de[0] = dbg1.err;     assign de[1] = dbg3.err;
   assign cr[0] = core1.rdata;  assign cr[1] = core3.rdata;
   assign dr[0] = dbg1.rdata;   assign dr[1] = dbg3.rdata;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: per-DUT "whose turn" flag plus a calendar of responses
   // keyed by the cycle they are due in. A reset cycle empties the calendar.
   // ------------------------------------------------------------------
   int unsigned cyc = 0;
   int          lat [2] = '{1, 3};
   logic        turn_dbg [2];
   logic        pv [2][8], po [2][8], pe [2][8], pw [2][8];
   logic        m_wc, m_wd, m_hit, m_we, m_ev;
   logic [31:0] m_addr, m_wdata, m_cr, m_dr;
   logic [3:0]  m_be;
   int          m_slot, m_due;

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         m_wc = 1'b0;
         m_wd = 1'b0;
         if (!rst) begin
            if (c_req && d_req) begin
               m_wd = turn_dbg[d];
               m_wc = !turn_dbg[d];
            end else begin
               m_wc = c_req;
               m_wd = d_req;
            end
         end
         m_addr  = m_wd ? d_addr  : (m_wc ? c_addr  : 32'h0);
         m_we    = m_wd ? d_we    : (m_wc ? c_we    : 1'b0);
         m_be    = m_wd ? d_be    : (m_wc ? c_be    : 4'h0);
         m_wdata = m_wd ? d_wdata : (m_wc ? c_wdata : 32'h0);
         m_hit   = (m_addr < 32'h0040_0000);

         chk($sformatf("core_gnt[%0d]", d), {31'h0, gc[d]}, {31'h0, m_wc});
         chk($sformatf("dbg_gnt[%0d]", d),  {31'h0, gd[d]}, {31'h0, m_wd});
         if ((m_wc || m_wd) && m_hit) begin
            chk($sformatf("ram_req[%0d]", d),   {31'h0, rr[d]}, 32'h1);
            chk($sformatf("ram_addr[%0d]", d),  {10'h0, ra[d]}, m_addr & 32'h003F_FFFF);
            chk($sformatf("ram_we[%0d]", d),    {31'h0, rw[d]}, {31'h0, m_we});
            chk($sformatf("ram_be[%0d]", d),    {28'h0, rb[d]}, {28'h0, m_be});
            chk($sformatf("ram_wdata[%0d]", d), rwd[d], m_wdata);
         end else begin
            chk($sformatf("ram_idle[%0d]", d),
                {rr[d], rw[d], rb[d], ra[d], 4'h0} | rwd[d], 32'h0);
         end

         m_slot = int'(cyc % 8);
         m_ev   = !rst && (pv[d][m_slot] === 1'b1);
         m_cr   = (m_ev && !po[d][m_slot] && !pe[d][m_slot] && !pw[d][m_slot]) ? rdata : 32'h0;
         m_dr   = (m_ev &&  po[d][m_slot] && !pe[d][m_slot] && !pw[d][m_slot]) ? rdata : 32'h0;
         chk($sformatf("core_rvalid[%0d]", d), {31'h0, cv[d]}, {31'h0, m_ev && !po[d][m_slot]});
         chk($sformatf("dbg_rvalid[%0d]", d),  {31'h0, dv[d]}, {31'h0, m_ev &&  po[d][m_slot]});
         chk($sformatf("core_err[%0d]", d),    {31'h0, ce[d]}, {31'h0, m_ev && !po[d][m_slot] && pe[d][m_slot]});
         chk($sformatf("dbg_err[%0d]", d),     {31'h0, de[d]}, {31'h0, m_ev &&  po[d][m_slot] && pe[d][m_slot]});
         chk($sformatf("core_rdata[%0d]", d),  cr[d], m_cr);
         chk($sformatf("dbg_rdata[%0d]", d),   dr[d], m_dr);

         pv[d][m_slot] = 1'b0;
         if (rst) begin
            for (int s = 0; s < 8; s++) pv[d][s] = 1'b0;
            turn_dbg[d] = 1'b0;
         end else if (m_wc || m_wd) begin
            m_due = int'((cyc + lat[d]) % 8);
            pv[d][m_due] = 1'b1;
            po[d][m_due] = m_wd;
            pe[d][m_due] = !m_hit;
            pw[d][m_due] = m_we;
            turn_dbg[d]  = m_wc;
         end
      end
      cyc++;
   end

   // ------------------------------------------------------------------
   // Directed stimulus with literal spot checks
   // ------------------------------------------------------------------
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      c_req = 0; c_addr = 0; c_we = 0; c_be = 0; c_wdata = 0;
      d_req = 0; d_addr = 0; d_we = 0; d_be = 0; d_wdata = 0;
   endtask

   task automatic core_rq(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] wd);
      c_req = 1; c_addr = a; c_we = w; c_be = b; c_wdata = wd;
   endtask

   task automatic dbg_rq(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] wd);
      d_req = 1; d_addr = a; d_we = w; d_be = b; d_wdata = wd;
   endtask

   task automatic do_reset();
      rst = 1; idle();
      nxt();
      @(negedge clk);
      chk("rst_core_rvalid", {31'h0, cv[0]}, 32'h0);
      chk("rst_ram_req", {31'h0, rr[0]}, 32'h0);
      nxt();
      rst = 0;
   endtask

   logic [3:0]  exp_core_order;
   logic [31:0] mix_addr [6];

   initial begin
      rst = 1; rdata = 32'h0;
      idle();
      do_reset();

      // 1: core read, data returned one cycle later
      core_rq(32'h0000_0100, 0, 4'hF, 32'h0);
      @(negedge clk);
      chk("t1_core_gnt", {31'h0, gc[0]}, 32'h1);
      nxt(); idle(); rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("t1_core_rvalid", {31'h0, cv[0]}, 32'h1);
      chk("t1_core_rdata", cr[0], 32'hDEAD_BEEF);
      chk("t1_core_err", {31'h0, ce[0]}, 32'h0);
      chk("t1_dbg_rvalid", {31'h0, dv[0]}, 32'h0);
      nxt(); nxt(); nxt();

      // 2: both requesting after reset alternate starting with core
      do_reset();
      exp_core_order = 4'b0101;
      for (int k = 0; k < 4; k++) begin
         core_rq(32'h0000_0200 + 32'(k * 4), 0, 4'hF, 32'h0);
         dbg_rq(32'h0000_0300 + 32'(k * 4), 0, 4'hF, 32'h0);
         rdata = 32'h2200_0000 + 32'(k);
         @(negedge clk);
         chk("t2_core_gnt", {31'h0, gc[0]}, {31'h0, exp_core_order[k]});
         chk("t2_dbg_gnt", {31'h0, gd[0]}, {31'h0, !exp_core_order[k]});
         chk("t2_ram_req", {31'h0, rr[0]}, 32'h1);
         nxt();
      end
      idle(); nxt(); nxt(); nxt();

      // 3: debug write outside the window -> error response, no RAM access
      dbg_rq(32'h0040_0000, 1, 4'hF, 32'h1234_5678);
      @(negedge clk);
      chk("t3_dbg_gnt", {31'h0, gd[0]}, 32'h1);
      chk("t3_ram_req", {31'h0, rr[0]}, 32'h0);
      nxt(); idle(); rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("t3_dbg_rvalid", {31'h0, dv[0]}, 32'h1);
      chk("t3_dbg_err", {31'h0, de[0]}, 32'h1);
      chk("t3_dbg_rdata", dr[0], 32'h0);
      nxt(); nxt(); nxt();

      // 4: alternating single reads; latency-3 instance returns them in order
      for (int k = 0; k < 8; k++) begin
         idle();
         rdata = 32'h1111_0000 + 32'(k);
         if (k < 4) begin
            if (k % 2 == 0) core_rq(32'h0000_1000 + 32'(k * 4), 0, 4'hF, 32'h0);
            else            dbg_rq(32'h0000_2000 + 32'(k * 4), 0, 4'hF, 32'h0);
         end
         @(negedge clk);
         if (k >= 3 && k <= 6) begin
            if ((k - 3) % 2 == 0) begin
               chk("t4_core_rvalid", {31'h0, cv[1]}, 32'h1);
               chk("t4_core_rdata", cr[1], 32'h1111_0000 + 32'(k));
               chk("t4_dbg_quiet", {31'h0, dv[1]}, 32'h0);
            end else begin
               chk("t4_dbg_rvalid", {31'h0, dv[1]}, 32'h1);
               chk("t4_dbg_rdata", dr[1], 32'h1111_0000 + 32'(k));
               chk("t4_core_quiet", {31'h0, cv[1]}, 32'h0);
            end
         end
         nxt();
      end

      // 5: reset right after a grant drops the response and re-arms core priority
      core_rq(32'h0000_0500, 0, 4'hF, 32'h0);
      @(negedge clk);
      chk("t5_core_gnt", {31'h0, gc[0]}, 32'h1);
      nxt(); idle(); rst = 1; rdata = 32'h5555_5555;
      @(negedge clk);
      chk("t5_no_rvalid", {31'h0, cv[0]}, 32'h0);
      chk("t5_gnt_gated", {31'h0, gc[0]}, 32'h0);
      nxt(); rst = 0;
      core_rq(32'h0000_0504, 0, 4'hF, 32'h0);
      dbg_rq(32'h0000_0508, 0, 4'hF, 32'h0);
      @(negedge clk);
      chk("t5_core_wins", {31'h0, gc[0]}, 32'h1);
      chk("t5_dbg_waits", {31'h0, gd[0]}, 32'h0);
      nxt(); idle(); nxt(); nxt(); nxt();

      // 6: byte write in window
      core_rq(32'h0000_0042, 1, 4'b0100, 32'h00AB_0000);
      @(negedge clk);
      chk("t6_ram_we", {31'h0, rw[0]}, 32'h1);
      chk("t6_ram_be", {28'h0, rb[0]}, 32'h4);
      chk("t6_ram_addr", {10'h0, ra[0]}, 32'h42);
      chk("t6_ram_wdata", rwd[0], 32'h00AB_0000);
      nxt(); idle(); rdata = 32'hCAFE_F00D;
      @(negedge clk);
      chk("t6_core_rvalid", {31'h0, cv[0]}, 32'h1);
      chk("t6_core_err", {31'h0, ce[0]}, 32'h0);
      chk("t6_core_rdata", cr[0], 32'h0);
      nxt(); nxt(); nxt();

      // Mixed traffic around the window edge, checked by the model only
      mix_addr = '{32'h003F_FFFC, 32'h0040_0000, 32'h0000_0000,
                   32'hFFFF_FFF0, 32'h003F_FFFF, 32'h8000_0010};
      for (int k = 0; k < 18; k++) begin
         idle();
         rdata = 32'h7700_0000 ^ 32'(k * 32'h0101);
         if (k % 3 != 2) core_rq(mix_addr[k % 6], k[0], 4'(k), 32'hC000_0000 + 32'(k));
         if (k % 4 != 0) dbg_rq(mix_addr[(k + 3) % 6], k[1], 4'(k + 5), 32'hD000_0000 + 32'(k));
         nxt();
      end
      idle();
      repeat (5) nxt();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
